// File: rtl/j_wbscore_pkg.sv
// Shared definitions for the Jerry DSP write-back scoreboard.
//   AW            register address width (bank bit + 5-bit register index)
//   REG_BANK_BIT  position of the bank-select bit inside an address
//   DEPTH_MIN/MAX legal range for the number of outstanding write-backs
//   CNT_W         width of the occupancy counter
//   wbs_entry_t   one pending write-back record {valid, addr}
//   addr_hit()    valid-gated full-width address equality
package j_wbscore_pkg;

  localparam int AW           = 6;
  localparam int REG_BANK_BIT = 5;
  localparam int DEPTH_MIN    = 2;
  localparam int DEPTH_MAX    = 8;
  localparam int CNT_W        = 4;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
  } wbs_entry_t;

  // Bitwise XNOR, AND-reduced, gated by valid; the bank bit takes part like any other bit.
  function automatic logic addr_hit(input wbs_entry_t e, input logic [AW-1:0] x);
    return e.valid & (&(e.addr ~^ x));
  endfunction

endpackage

// File: rtl/j_wbs_match.sv
// One scoreboard slot: holds a single {valid, addr} record and compares it
// against the three live addresses of the instruction at the issue stage.
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   flush_i        clears the valid bit (wins over set/clear)
//   set_i, addr_i  load a new pending destination into this slot
//   clr_i          drop the valid bit (this slot is the retiring head)
//   srca_i/srcb_i/dsta_i  addresses to compare
//   addr_o         stored address (feeds the retire_addr mux)
//   match_*_o      slot is valid and equals the corresponding address
module j_wbs_match
  import j_wbscore_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          set_i,
  input  logic [AW-1:0] addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] srca_i,
  input  logic [AW-1:0] srcb_i,
  input  logic [AW-1:0] dsta_i,
  output logic [AW-1:0] addr_o,
  output logic          match_a_o,
  output logic          match_b_o,
  output logic          match_d_o
);

  wbs_entry_t entry_q;
  wbs_entry_t entry_d;

  // Next-state selection for the slot record; flush only drops valid, stale addr is harmless.
  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid = 1'b0;
    end else if (set_i) begin
      entry_d.valid = 1'b1;
      entry_d.addr  = addr_i;
    end else if (clr_i) begin
      entry_d.valid = 1'b0;
    end else begin
      entry_d = entry_q;
    end
  end

  // Slot storage register, fully cleared on reset so retire_addr reads 0 afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '{valid: 1'b0, addr: {AW{1'b0}}};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign addr_o    = entry_q.addr;
  assign match_a_o = addr_hit(entry_q, srca_i);
  assign match_b_o = addr_hit(entry_q, srcb_i);
  assign match_d_o = addr_hit(entry_q, dsta_i);

endmodule

// File: rtl/j_wbscore.sv
// Write-back scoreboard: in-order FIFO of pending destination registers with
// hazard detection against all in-flight entries.
//   sys_clk, resetl       clock, asynchronous active-low reset
//   flush                 synchronous clear of every pending entry (highest priority)
//   issue_valid/addr      push a destination; accepted when issue_ready
//   issue_ready           a slot is free (depends on registered count only)
//   retire_valid          pop the oldest entry
//   retire_addr           address at the head of the FIFO
//   srca/srcb/dsta        issue-stage addresses; hazard_a/b/d flag a pending match
//   count, empty          occupancy
//   retire_err            registered one-cycle pulse for a retire while empty
module j_wbscore
  import j_wbscore_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  output logic             issue_ready,
  input  logic             retire_valid,
  output logic [AW-1:0]    retire_addr,
  input  logic [AW-1:0]    srca,
  input  logic [AW-1:0]    srcb,
  input  logic [AW-1:0]    dsta,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             hazard_d,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             retire_err
);

  localparam int                PW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]     LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire_err_q, retire_err_d;

  logic             empty_s;
  logic             ready_s;
  logic             accept_s;
  logic             pop_s;
  logic [DEPTH-1:0] match_a_s;
  logic [DEPTH-1:0] match_b_s;
  logic [DEPTH-1:0] match_d_s;
  logic [AW-1:0]    addr_s [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  assign empty_s  = (count_q == {CNT_W{1'b0}});
  assign ready_s  = (count_q != FULL_CNT);
  // Flush discards any concurrent issue or retire.
  assign accept_s = issue_valid & ready_s & ~flush;
  assign pop_s    = retire_valid & ~empty_s & ~flush;

  // Pointer, occupancy and error-pulse next-state logic.
  always_comb begin
    wr_d         = wr_q;
    rd_d         = rd_q;
    count_d      = count_q;
    retire_err_d = 1'b0;
    if (flush) begin
      wr_d         = {PW{1'b0}};
      rd_d         = {PW{1'b0}};
      count_d      = {CNT_W{1'b0}};
      retire_err_d = 1'b0;
    end else begin
      if (accept_s) begin
        wr_d = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      count_d      = count_q + CNT_W'(accept_s) - CNT_W'(pop_s);
      retire_err_d = retire_valid & empty_s;
    end
  end

  // Control-state registers.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      wr_q         <= {PW{1'b0}};
      rd_q         <= {PW{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      retire_err_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      retire_err_q <= retire_err_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    j_wbs_match u_match (
      .clk_i     (sys_clk),
      .rst_ni    (resetl),
      .flush_i   (flush),
      .set_i     (accept_s & (wr_q == PW'(i))),
      .addr_i    (issue_addr),
      .clr_i     (pop_s & (rd_q == PW'(i))),
      .srca_i    (srca),
      .srcb_i    (srcb),
      .dsta_i    (dsta),
      .addr_o    (addr_s[i]),
      .match_a_o (match_a_s[i]),
      .match_b_o (match_b_s[i]),
      .match_d_o (match_d_s[i])
    );
  end

  assign issue_ready = ready_s;
  assign retire_addr = addr_s[rd_q];
  assign hazard_a    = |match_a_s;
  assign hazard_b    = |match_b_s;
  assign hazard_d    = |match_d_s;
  assign count       = count_q;
  assign empty       = empty_s;
  assign retire_err  = retire_err_q;

endmodule

// File: tb/tb_j_wbscore.sv
module tb_j_wbscore;

  logic       sys_clk = 1'b0;
  logic       resetl;
  logic       flush;
  logic       issue_valid;
  logic [5:0] issue_addr;
  logic       issue_ready;
  logic       retire_valid;
  logic [5:0] retire_addr;
  logic [5:0] srca, srcb, dsta;
  logic       hazard_a, hazard_b, hazard_d;
  logic [3:0] count;
  logic       empty;
  logic       retire_err;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain in-order queue of pending destinations.
  logic [5:0] mq[$];
  logic       merr;

  typedef struct {
    logic       fl, iv;
    logic [5:0] ia;
    logic       rv;
    logic [5:0] sa, sb, sd;
    logic [3:0] cnt;
    logic       rdy, emp, ha, hb, hd;
    logic [5:0] head;
    logic       err;
  } vec_t;

  vec_t tbl[24];

  j_wbscore #(.DEPTH(4)) dut (
    .sys_clk      (sys_clk),
    .resetl       (resetl),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .retire_valid (retire_valid),
    .retire_addr  (retire_addr),
    .srca         (srca),
    .srcb         (srcb),
    .dsta         (dsta),
    .hazard_a     (hazard_a),
    .hazard_b     (hazard_b),
    .hazard_d     (hazard_d),
    .count        (count),
    .empty        (empty),
    .retire_err   (retire_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic in_q(input logic [5:0] x);
    foreach (mq[i]) if (mq[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t mk(input logic fl, iv, input logic [5:0] ia, input logic rv,
                              input logic [5:0] sa, sb, sd, input logic [3:0] cnt,
                              input logic rdy, emp, ha, hb, hd, input logic [5:0] head,
                              input logic err);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ia = ia; v.rv = rv; v.sa = sa; v.sb = sb; v.sd = sd;
    v.cnt = cnt; v.rdy = rdy; v.emp = emp; v.ha = ha; v.hb = hb; v.hd = hd;
    v.head = head; v.err = err;
    return v;
  endfunction

  // Apply the rules to the model as of one rising edge.
  task automatic model_step(input logic fl, iv, input logic [5:0] ia, input logic rv);
    int  n;
    bit  acc, ret;
    n = mq.size();
    if (fl) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      acc  = iv && (n != 4);
      ret  = rv && (n > 0);
      merr = rv && (n == 0);
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back(ia);
    end
  endtask

  task automatic drive(input logic fl, iv, input logic [5:0] ia, input logic rv,
                       input logic [5:0] sa, sb, sd);
    flush = fl; issue_valid = iv; issue_addr = ia; retire_valid = rv;
    srca = sa; srcb = sb; dsta = sd;
  endtask

  // One cycle checked against the reference model.
  task automatic cycle_model(input logic fl, iv, input logic [5:0] ia, input logic rv,
                             input logic [5:0] sa, sb, sd);
    drive(fl, iv, ia, rv, sa, sb, sd);
    @(posedge sys_clk);
    model_step(fl, iv, ia, rv);
    #1;
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_ready", 32'(issue_ready), 32'(mq.size() != 4));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_err", 32'(retire_err), 32'(merr));
    chk("m_haz_a", 32'(hazard_a), 32'(in_q(sa)));
    chk("m_haz_b", 32'(hazard_b), 32'(in_q(sb)));
    chk("m_haz_d", 32'(hazard_d), 32'(in_q(sd)));
    if (mq.size() > 0) chk("m_head", 32'(retire_addr), 32'(mq[0]));
  endtask

  function automatic logic [5:0] pick();
    int k;
    if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, mq.size() - 1);
      if ($urandom_range(0, 3) == 0) return mq[k] ^ 6'h20;
      return mq[k];
    end
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    logic       fl, iv, rv;
    logic [5:0] ia;
    resetl = 1'b0;
    drive(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, 6'h00, 6'h00);
    merr = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_err", 32'(retire_err), 32'd0);
    chk("rst_head", 32'(retire_addr), 32'd0);
    chk("rst_haz", 32'({hazard_a, hazard_b, hazard_d}), 32'd0);
    @(negedge sys_clk);
    resetl = 1'b1;

    //            fl    iv    ia     rv    sa     sb     sd     cnt   rdy   emp   ha    hb    hd    head   err
    tbl[0]  = mk(1'b0, 1'b1, 6'h05, 1'b0, 6'h05, 6'h25, 6'h00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h05, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h05, 6'h25, 6'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 6'h01, 1'b0, 6'h01, 6'h02, 6'h04, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h01, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 6'h02, 1'b0, 6'h01, 6'h02, 6'h04, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h01, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 6'h03, 1'b0, 6'h01, 6'h02, 6'h04, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h01, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 6'h04, 1'b0, 6'h01, 6'h02, 6'h04, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h01, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 6'h10, 1'b0, 6'h10, 6'h01, 6'h04, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h01, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 6'h10, 1'b1, 6'h10, 6'h01, 6'h04, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h02, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 6'h10, 1'b0, 6'h10, 6'h01, 6'h04, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h02, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 6'h03, 6'h10, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h03, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 6'h03, 6'h10, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h04, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 6'h03, 6'h10, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h10, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 6'h03, 6'h10, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 6'h03, 6'h10, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 6'h00, 1'b0, 6'h02, 6'h03, 6'h10, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 6'h07, 1'b1, 6'h07, 6'h00, 6'h07, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07, 1'b1);
    tbl[16] = mk(1'b0, 1'b1, 6'h07, 1'b0, 6'h07, 6'h00, 6'h07, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h07, 6'h00, 6'h07, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07, 1'b0);
    tbl[18] = mk(1'b1, 1'b1, 6'h07, 1'b0, 6'h07, 6'h00, 6'h07, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[19] = mk(1'b1, 1'b0, 6'h00, 1'b1, 6'h07, 6'h00, 6'h07, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[20] = mk(1'b0, 1'b0, 6'h00, 1'b0, 6'h07, 6'h00, 6'h07, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    tbl[21] = mk(1'b0, 1'b1, 6'h11, 1'b0, 6'h11, 6'h12, 6'h00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h11, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, 6'h12, 1'b1, 6'h11, 6'h12, 6'h00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h12, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 6'h00, 1'b1, 6'h11, 6'h12, 6'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ia, tbl[i].rv, tbl[i].sa, tbl[i].sb, tbl[i].sd);
      @(posedge sys_clk);
      model_step(tbl[i].fl, tbl[i].iv, tbl[i].ia, tbl[i].rv);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("v%0d_haz_a", i), 32'(hazard_a), 32'(tbl[i].ha));
      chk($sformatf("v%0d_haz_b", i), 32'(hazard_b), 32'(tbl[i].hb));
      chk($sformatf("v%0d_haz_d", i), 32'(hazard_d), 32'(tbl[i].hd));
      chk($sformatf("v%0d_err", i), 32'(retire_err), 32'(tbl[i].err));
      if (!tbl[i].emp) chk($sformatf("v%0d_head", i), 32'(retire_addr), 32'(tbl[i].head));
    end

    // Ten issue/retire pairs walk both pointers around the ring more than twice.
    for (int i = 0; i < 10; i++) begin
      ia = 6'((i * 7 + 3) % 64);
      cycle_model(1'b0, 1'b1, ia, 1'b0, ia, ia ^ 6'h20, 6'h3f);
      cycle_model(1'b0, 1'b0, 6'h00, 1'b1, ia, ia ^ 6'h20, 6'h3f);
    end

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 31) == 0);
      iv = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0);
      ia = 6'($urandom_range(0, 63)) & 6'h27;
      cycle_model(fl, iv, ia, rv, pick(), pick(), pick());
    end

    // Asynchronous reset in the middle of a run with three entries pending.
    cycle_model(1'b1, 1'b0, 6'h00, 1'b0, 6'h00, 6'h00, 6'h00);
    cycle_model(1'b0, 1'b1, 6'h21, 1'b0, 6'h21, 6'h22, 6'h23);
    cycle_model(1'b0, 1'b1, 6'h22, 1'b0, 6'h21, 6'h22, 6'h23);
    cycle_model(1'b0, 1'b1, 6'h23, 1'b0, 6'h21, 6'h22, 6'h23);
    drive(1'b0, 1'b0, 6'h00, 1'b0, 6'h21, 6'h22, 6'h23);
    @(negedge sys_clk);
    #2;
    resetl = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_ready", 32'(issue_ready), 32'd1);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_haz", 32'({hazard_a, hazard_b, hazard_d}), 32'd0);
    chk("mrst_head", 32'(retire_addr), 32'd0);
    mq.delete();
    merr = 1'b0;
    @(negedge sys_clk);
    resetl = 1'b1;
    cycle_model(1'b0, 1'b1, 6'h21, 1'b0, 6'h21, 6'h01, 6'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
